psum_control_unit: RTL and testbench



---
 rtl/psum_ctrl_pkg.sv | 16 +
 rtl/psum_control_unit_skew.sv | 23 ++
 rtl/psum_control_unit.sv | 267 ++++++++++++++++++++++++++
 tb/tb_psum_control_unit.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/psum_ctrl_pkg.sv
// Shared types for the partial-sum controller: FSM state encoding and lane-group helper.
package psum_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_OLOAD = 2'd2,
        S_FIN   = 2'd3
    } state_e;

    // Output-buffer words needed to carry one psum row.
    function automatic logic [15:0] lane_groups(input int unsigned col, input int unsigned ndata);
        return 16'(col / ndata);
    endfunction

endpackage

// File: rtl/psum_control_unit_skew.sv
// Diagonal write-enable generator: delays one N-cycle window by one cycle per column.
module psum_skew_gen #(
    parameter int COL = 8
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic           window_i,
    output logic [COL-1:0] we_o
);

    logic [COL-1:0] sr_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sr_q <= '0;
        end else begin
            sr_q <= (sr_q << 1) | COL'(window_i);
        end
    end

    assign we_o = sr_q;

endmodule

// File: rtl/psum_control_unit.sv
// Sequences aligner and psum read-accumulate-write after each tile, and drains psums
// to an output buffer. The drain path exists only when PSUM_CTRL_OUTPUTLOAD_EN is defined.
module psum_control_unit
    import psum_ctrl_pkg::*;
#(
    parameter int ROW               = 8,
    parameter int COL               = 8,
    parameter int NDATA             = 4,
    parameter int P_BRAM_ADDR_WIDTH = 5,
    parameter int O_BRAM_ADDR_WIDTH = 7
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         start,
    input  logic                         is_first_psum,
    input  logic                         is_outputload,
    output logic                         outputload_fin,
    input  logic                         o_sel,
    input  logic [7:0]                   A,
    input  logic [7:0]                   C,
    input  logic [7:0]                   L,
    input  logic [P_BRAM_ADDR_WIDTH-1:0] psum_baseaddr,
    input  logic                         psum_ctrl_sel,
    output logic                         p_allign_rstn,
    output logic                         p_allign_en,
    output logic [COL-1:0]               p_allign_we,
    output logic                         p_allign_re,
    output logic                         psum_sel,
    output logic                         first_psum,
    output logic                         psum_en,
    output logic                         psum_we,
    output logic [O_BRAM_ADDR_WIDTH-1:0] psum_addr,
    output logic [O_BRAM_ADDR_WIDTH-1:0] psum_prev_addr,
    output logic                         o_buf0_en,
    output logic                         o_buf0_we,
    output logic [O_BRAM_ADDR_WIDTH-1:0] o_buf0_addr,
    output logic                         o_buf1_en,
    output logic                         o_buf1_we,
    output logic [O_BRAM_ADDR_WIDTH-1:0] o_buf1_addr
);

    localparam int          AW    = O_BRAM_ADDR_WIDTH;
    localparam logic [15:0] COL16 = 16'(COL);
`ifdef PSUM_CTRL_OUTPUTLOAD_EN
    localparam logic [15:0] G16        = lane_groups(COL, NDATA);
    localparam state_e      LOAD_STATE = S_OLOAD;
`else
    localparam state_e      LOAD_STATE = S_FIN;
`endif

    state_e                       state_q, state_d;
    logic [15:0]                  cyc_q, cyc_d, n_q, n_d;
    logic [P_BRAM_ADDR_WIDTH-1:0] base_q, base_d;
    logic                         first_q, first_d, sel_q, sel_d;
    logic                         allign_rstn_q, allign_rstn_d, allign_en_q, allign_en_d;
    logic                         allign_re_q, allign_re_d, window_d;
    logic                         psum_en_q, psum_en_d, psum_we_q, psum_we_d, fin_q, fin_d;
    logic [AW-1:0]                psum_addr_q, psum_addr_d, prev_addr_q, prev_addr_d;
`ifdef PSUM_CTRL_OUTPUTLOAD_EN
    logic [15:0]                  e_q, e_d, w_q, w_d, total_q, total_d;
    logic                         osel_q, osel_d;
    logic                         ob0_en_q, ob0_en_d, ob1_en_q, ob1_en_d;
    logic [AW-1:0]                ob_addr_q, ob_addr_d;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= S_IDLE;
            cyc_q         <= '0;
            n_q           <= '0;
            base_q        <= '0;
            first_q       <= 1'b0;
            sel_q         <= 1'b0;
            allign_rstn_q <= 1'b0;
            allign_en_q   <= 1'b0;
            allign_re_q   <= 1'b0;
            psum_en_q     <= 1'b0;
            psum_we_q     <= 1'b0;
            fin_q         <= 1'b0;
            psum_addr_q   <= '0;
            prev_addr_q   <= '0;
`ifdef PSUM_CTRL_OUTPUTLOAD_EN
            e_q           <= '0;
            w_q           <= '0;
            total_q       <= '0;
            osel_q        <= 1'b0;
            ob0_en_q      <= 1'b0;
            ob1_en_q      <= 1'b0;
            ob_addr_q     <= '0;
`endif
        end else begin
            state_q       <= state_d;
            cyc_q         <= cyc_d;
            n_q           <= n_d;
            base_q        <= base_d;
            first_q       <= first_d;
            sel_q         <= sel_d;
            allign_rstn_q <= allign_rstn_d;
            allign_en_q   <= allign_en_d;
            allign_re_q   <= allign_re_d;
            psum_en_q     <= psum_en_d;
            psum_we_q     <= psum_we_d;
            fin_q         <= fin_d;
            psum_addr_q   <= psum_addr_d;
            prev_addr_q   <= prev_addr_d;
`ifdef PSUM_CTRL_OUTPUTLOAD_EN
            e_q           <= e_d;
            w_q           <= w_d;
            total_q       <= total_d;
            osel_q        <= osel_d;
            ob0_en_q      <= ob0_en_d;
            ob1_en_q      <= ob1_en_d;
            ob_addr_q     <= ob_addr_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        n_d     = n_q;
        base_d  = base_q;
        first_d = first_q;
        sel_d   = sel_q;
`ifdef PSUM_CTRL_OUTPUTLOAD_EN
        e_d     = e_q;
        w_d     = w_q;
        total_d = total_q;
        osel_d  = osel_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_ACCUM;
                    cyc_d   = '0;
                    n_d     = 16'(L) * COL16;
                    base_d  = psum_baseaddr;
                    first_d = is_first_psum;
                    sel_d   = psum_ctrl_sel;
                end else if (is_outputload) begin
                    state_d = LOAD_STATE;
                end
            end
            S_ACCUM: begin
                // Last write-back lands COL+1 cycles after the final row enters the aligner.
                if (cyc_q == COL16 + n_q + 16'd1) begin
                    cyc_d   = '0;
                    state_d = is_outputload ? LOAD_STATE : S_IDLE;
                end else begin
                    cyc_d = cyc_q + 16'd1;
                end
            end
`ifdef PSUM_CTRL_OUTPUTLOAD_EN
            S_OLOAD: begin
                if (cyc_q == total_q) begin
                    state_d = S_FIN;
                end else begin
                    cyc_d = cyc_q + 16'd1;
                    if (w_q == G16 - 16'd1) begin
                        w_d = '0;
                        e_d = e_q + 16'd1;
                    end else begin
                        w_d = w_q + 16'd1;
                    end
                end
            end
`endif
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
`ifdef PSUM_CTRL_OUTPUTLOAD_EN
        if (state_d == S_OLOAD && state_q != S_OLOAD) begin
            cyc_d   = '0;
            e_d     = '0;
            w_d     = '0;
            total_d = 16'(ROW) * 16'(A) * 16'(C) * G16;
            osel_d  = o_sel;
        end
        if (state_d == S_OLOAD) begin
            sel_d = psum_ctrl_sel;
        end
`endif
    end

    // Registered outputs are decoded from the next state so they line up with the cycle count.
    always_comb begin
        allign_rstn_d = 1'b0;
        allign_en_d   = 1'b0;
        allign_re_d   = 1'b0;
        window_d      = 1'b0;
        psum_en_d     = 1'b0;
        psum_we_d     = 1'b0;
        fin_d         = 1'b0;
        psum_addr_d   = '0;
        prev_addr_d   = '0;
`ifdef PSUM_CTRL_OUTPUTLOAD_EN
        ob0_en_d      = 1'b0;
        ob1_en_d      = 1'b0;
        ob_addr_d     = '0;
`endif
        case (state_d)
            S_ACCUM: begin
                allign_rstn_d = 1'b1;
                window_d      = (cyc_d >= 16'd1) && (cyc_d <= n_d);
                allign_en_d   = (cyc_d >= 16'd1) && (cyc_d <= COL16 + n_d - 16'd1);
                allign_re_d   = (cyc_d >= COL16 + 16'd1) && (cyc_d <= COL16 + n_d);
                psum_we_d     = (cyc_d >= COL16 + 16'd2) && (cyc_d <= COL16 + n_d + 16'd1);
                psum_en_d     = allign_re_d | psum_we_d;
                if (allign_re_d) prev_addr_d = AW'(base_d) + AW'(cyc_d - COL16 - 16'd1);
                if (psum_we_d)   psum_addr_d = AW'(base_d) + AW'(cyc_d - COL16 - 16'd2);
            end
`ifdef PSUM_CTRL_OUTPUTLOAD_EN
            S_OLOAD: begin
                psum_en_d = (cyc_d < total_d);
                if (psum_en_d) begin
                    prev_addr_d = AW'(e_d);
                    psum_addr_d = AW'(w_d);
                end
                if (cyc_d != 16'd0) begin
                    ob0_en_d  = ~osel_d;
                    ob1_en_d  = osel_d;
                    ob_addr_d = AW'(cyc_d - 16'd1);
                end
            end
`endif
            S_FIN:   fin_d = 1'b1;
            default: ;
        endcase
    end

    psum_skew_gen #(.COL(COL)) u_skew (
        .clk      (clk),
        .rstn     (rstn),
        .window_i (window_d),
        .we_o     (p_allign_we)
    );

    assign p_allign_rstn  = allign_rstn_q;
    assign p_allign_en    = allign_en_q;
    assign p_allign_re    = allign_re_q;
    assign psum_sel       = sel_q;
    assign first_psum     = first_q;
    assign psum_en        = psum_en_q;
    assign psum_we        = psum_we_q;
    assign psum_addr      = psum_addr_q;
    assign psum_prev_addr = prev_addr_q;
    assign outputload_fin = fin_q;

`ifdef PSUM_CTRL_OUTPUTLOAD_EN
    assign o_buf0_en   = ob0_en_q;
    assign o_buf0_we   = ob0_en_q;
    assign o_buf0_addr = ob0_en_q ? ob_addr_q : '0;
    assign o_buf1_en   = ob1_en_q;
    assign o_buf1_we   = ob1_en_q;
    assign o_buf1_addr = ob1_en_q ? ob_addr_q : '0;
`else
    logic unused_oload;
    assign unused_oload = ^{o_sel, A, C, 1'(ROW), 1'(NDATA)};
    assign o_buf0_en    = 1'b0;
    assign o_buf0_we    = 1'b0;
    assign o_buf0_addr  = '0;
    assign o_buf1_en    = 1'b0;
    assign o_buf1_we    = 1'b0;
    assign o_buf1_addr  = '0;
`endif

endmodule

// File: tb/tb_psum_control_unit.sv
// Self-checking bench for psum_control_unit; expectations follow PSUM_CTRL_OUTPUTLOAD_EN.
module tb_psum_control_unit;

    localparam int ROW = 8;
    localparam int COL = 8;
    localparam int G   = 2;
    localparam int AM  = 128;

    logic       clk, rstn, start, is_first_psum, is_outputload, o_sel, psum_ctrl_sel;
    logic [7:0] A, C, L;
    logic [4:0] psum_baseaddr;
    logic       outputload_fin, p_allign_rstn, p_allign_en, p_allign_re, psum_sel, first_psum;
    logic [7:0] p_allign_we;
    logic       psum_en, psum_we, o_buf0_en, o_buf0_we, o_buf1_en, o_buf1_we;
    logic [6:0] psum_addr, psum_prev_addr, o_buf0_addr, o_buf1_addr;

    int n_checks = 0;
    int n_fail   = 0;

    psum_control_unit dut (
        .clk(clk), .rstn(rstn), .start(start), .is_first_psum(is_first_psum),
        .is_outputload(is_outputload), .outputload_fin(outputload_fin), .o_sel(o_sel),
        .A(A), .C(C), .L(L), .psum_baseaddr(psum_baseaddr), .psum_ctrl_sel(psum_ctrl_sel),
        .p_allign_rstn(p_allign_rstn), .p_allign_en(p_allign_en), .p_allign_we(p_allign_we),
        .p_allign_re(p_allign_re), .psum_sel(psum_sel), .first_psum(first_psum),
        .psum_en(psum_en), .psum_we(psum_we), .psum_addr(psum_addr),
        .psum_prev_addr(psum_prev_addr),
        .o_buf0_en(o_buf0_en), .o_buf0_we(o_buf0_we), .o_buf0_addr(o_buf0_addr),
        .o_buf1_en(o_buf1_en), .o_buf1_we(o_buf1_we), .o_buf1_addr(o_buf1_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_ctrl"}, 32'({p_allign_rstn, p_allign_en, p_allign_we, p_allign_re, psum_sel,
             first_psum, psum_en, psum_we, outputload_fin, o_buf0_en, o_buf0_we,
             o_buf1_en, o_buf1_we}), 32'd0);
        chk({tag, "_addr"}, 32'({psum_addr, psum_prev_addr, o_buf0_addr, o_buf1_addr}), 32'd0);
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_idle"}, 32'({p_allign_rstn, p_allign_en, p_allign_we, p_allign_re, psum_en,
             psum_we, outputload_fin, o_buf0_en, o_buf1_en}), 32'd0);
    endtask

    // Cycle k of a run (k = 0 is the edge that took start); n rows, latched base/first/sel.
    task automatic check_accum(input int k, input int n, input int base, input bit first, input bit sel);
        logic [7:0] we_e;
        bit rd, wr;
        for (int c = 0; c < COL; c++) we_e[c] = (k >= 1 + c) && (k <= n + c);
        rd = (k >= COL + 1) && (k <= COL + n);
        wr = (k >= COL + 2) && (k <= COL + n + 1);
        chk("accum_rstn", 32'(p_allign_rstn), 32'd1);
        chk("accum_allign_we", 32'(p_allign_we), 32'(we_e));
        chk("accum_allign_en", 32'(p_allign_en), 32'((k >= 1) && (k <= n + COL - 1)));
        chk("accum_allign_re", 32'(p_allign_re), 32'(rd));
        chk("accum_psum_en", 32'(psum_en), 32'(rd || wr));
        chk("accum_psum_we", 32'(psum_we), 32'(wr));
        if (rd) chk("accum_rd_addr", 32'(psum_prev_addr), 32'((base + k - COL - 1) % AM));
        if (wr) chk("accum_wr_addr", 32'(psum_addr), 32'((base + k - COL - 2) % AM));
        chk("accum_first", 32'(first_psum), 32'(first));
        chk("accum_sel", 32'(psum_sel), 32'(sel));
        chk("accum_quiet", 32'({outputload_fin, o_buf0_en, o_buf1_en}), 32'd0);
    endtask

    // Called at the negedge of the first cycle after the transition into the drain.
    task automatic drain_check(input int a, input int c, input bit osel);
`ifdef PSUM_CTRL_OUTPUTLOAD_EN
        int t;
        bit rd, wr;
        t = (ROW * a * c * G) % 65536;
        for (int j = 0; j <= t; j++) begin
            rd = (j < t);
            wr = (j >= 1);
            chk("drain_psum_en", 32'(psum_en), 32'(rd));
            chk("drain_psum_we", 32'(psum_we), 32'd0);
            if (rd) chk("drain_entry", 32'(psum_prev_addr), 32'((j / G) % AM));
            if (rd) chk("drain_lane", 32'(psum_addr), 32'(j % G));
            chk("drain_sel_buf", 32'({o_buf1_en, o_buf1_we}), osel ? 32'({wr, wr}) : 32'd0);
            chk("drain_other_buf", 32'({o_buf0_en, o_buf0_we}), osel ? 32'd0 : 32'({wr, wr}));
            if (wr) chk("drain_waddr", 32'(osel ? o_buf1_addr : o_buf0_addr), 32'((j - 1) % AM));
            chk("drain_idle_addr", 32'(osel ? o_buf0_addr : o_buf1_addr), 32'd0);
            chk("drain_psum_sel", 32'(psum_sel), 32'(psum_ctrl_sel));
            chk("drain_quiet", 32'({p_allign_rstn, p_allign_en, outputload_fin}), 32'd0);
            @(negedge clk);
        end
`endif
        chk("fin_pulse", 32'(outputload_fin), 32'd1);
        chk("fin_bufs", 32'({o_buf0_en, o_buf1_en, psum_en}), 32'd0);
        is_outputload = 1'b0;
        @(negedge clk);
        chk("fin_single", 32'(outputload_fin), 32'd0);
        check_idle("after_fin");
        $display("drain a=%0d c=%0d o_sel=%0d done", a, c, osel);
    endtask

    // ol_at: cycle at which is_outputload rises (-2 = together with start, -1 = never).
    task automatic run_accum(input int l, input int base, input bit first, input bit sel,
                             input int ol_at, input int start_at, input int abort_at);
        int n;
        n = l * COL;
        L = 8'(l);
        psum_baseaddr = 5'(base);
        is_first_psum = first;
        psum_ctrl_sel = sel;
        start = 1'b1;
        if (ol_at == -2) is_outputload = 1'b1;
        @(negedge clk);
        for (int k = 0; k <= COL + n + 1; k++) begin
            if (k == abort_at) begin
                rstn = 1'b0;
                #1;
                check_reset("abort");
                @(negedge clk);
                rstn = 1'b1;
                $display("run L=%0d base=%0d aborted at cycle %0d", l, base, k);
                return;
            end
            check_accum(k, n, base, first, sel);
            start = (k == start_at);
            if (k == ol_at) is_outputload = 1'b1;
            if (k == 0) begin
                is_first_psum = ~first;
                psum_ctrl_sel = ~sel;
                psum_baseaddr = ~psum_baseaddr;
            end
            @(negedge clk);
        end
        start = 1'b0;
        $display("run L=%0d base=%0d first=%0d sel=%0d done", l, base, first, sel);
    endtask

    initial begin
        int l, b, a, c;
        rstn = 1'b0; start = 1'b0; is_first_psum = 1'b0; is_outputload = 1'b0;
        o_sel = 1'b0; psum_ctrl_sel = 1'b0; A = 8'd1; C = 8'd1; L = 8'd1; psum_baseaddr = '0;
        @(negedge clk); @(negedge clk);
        check_reset("reset");
        rstn = 1'b1;
        @(negedge clk);
        check_idle("post_reset");

        run_accum(1, 0, 1'b1, 1'b0, -1, -1, -1);
        check_idle("t1");
        run_accum(2, 8, 1'b0, 1'b1, -1, -1, -1);
        check_idle("t2");

        A = 8'd1; C = 8'd1; o_sel = 1'b1; is_outputload = 1'b1;
        @(negedge clk);
        drain_check(1, 1, 1'b1);

        A = 8'd1; C = 8'd2; o_sel = 1'b0;
        run_accum(1, 3, 1'b0, 1'b0, 3, 5, -1);
        drain_check(1, 2, 1'b0);

        A = 8'd2; C = 8'd1; o_sel = 1'b1;
        run_accum(1, 5, 1'b1, 1'b1, -2, -1, -1);
        drain_check(2, 1, 1'b1);

        run_accum(1, 0, 1'b1, 1'b1, -1, -1, 6);
        run_accum(1, 0, 1'b1, 1'b0, -1, -1, -1);
        check_idle("after_abort");

        run_accum(4, 31, 1'b0, 1'b1, -1, -1, -1);
        check_idle("base31_l4");
        run_accum(13, 31, 1'b1, 1'b0, -1, -1, -1);
        check_idle("wrap");

        for (int i = 0; i < 6; i++) begin
            l = int'($urandom_range(1, 5));
            b = int'($urandom_range(0, 31));
            run_accum(l, b, 1'($urandom), 1'($urandom), -1, int'($urandom_range(1, 8)), -1);
            check_idle("rand_run");
        end
        for (int i = 0; i < 3; i++) begin
            a = int'($urandom_range(1, 3));
            c = int'($urandom_range(1, 3));
            A = 8'(a); C = 8'(c); o_sel = 1'($urandom);
            psum_ctrl_sel = 1'($urandom);
            is_outputload = 1'b1;
            @(negedge clk);
            drain_check(a, c, o_sel);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
